// File: rtl/ioctl_mem_arbiter.sv
// ioctl_mem_arbiter: packs data_io download bytes into 16-bit words and round-robins them with a core requester onto one memory port.
// Optional IOCTL_ARB_STATS_EN adds dl_words/overrun status outputs.
module ioctl_mem_arbiter #(
  parameter int          CLKREF_DIV = 4,
  parameter logic [23:0] ADDR_BASE  = 24'h000000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        clkref_n,
  output logic        dl_done,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [23:0] core_addr,
  input  logic [15:0] core_din,
  input  logic [1:0]  core_ds,
  output logic        core_ack,
  output logic [15:0] core_q,
  output logic        mem_req,
  output logic        mem_we,
  output logic [23:0] mem_addr,
  output logic [15:0] mem_din,
  output logic [1:0]  mem_ds,
  input  logic        mem_ack,
  input  logic [15:0] mem_q
`ifdef IOCTL_ARB_STATS_EN
  ,
  output logic [23:0] dl_words,
  output logic        overrun
`endif
);
  typedef enum logic [1:0] {IDLE, DL_WR, CORE} state_t;
  typedef struct packed {
    logic [23:0] wa;
    logic [15:0] d;
    logic [1:0]  ds;
  } ent_t;

  state_t      state, nxt;
  ent_t        q [2];
  ent_t        nq [2];
  ent_t        ea, eb, hold_e, odd_e;
  logic [1:0]  cnt, ncnt;
  logic        hold_v, hv_n;
  logic [23:0] hold_wa, hwa_n, wa;
  logic [7:0]  hold_b, hb_n, div_cnt, div_n;
  logic        dl_q, flush_pend, flush_go, done_pend, done_go, last_core, core_drop;
  logic        acc, pop, push_a, push_b;

  assign wa       = ioctl_addr[24:1] + ADDR_BASE;
  assign acc      = ioctl_wr && cnt == 2'd0;
  assign pop      = state == DL_WR && mem_ack;
  assign hold_e   = {hold_wa, 8'h00, hold_b, 2'b01};
  assign odd_e    = {wa, ioctl_dout, 8'h00, 2'b10};
  // the tail flush yields to an accepted byte and waits for queue room
  assign flush_go = flush_pend && !acc && (!hold_v || cnt != 2'd2 || pop);
  assign done_go  = done_pend && !ioctl_download && !flush_pend && !hold_v && cnt == 2'd0;
  assign div_n    = (div_cnt == 8'(CLKREF_DIV - 1)) ? 8'd0 : div_cnt + 8'd1;

  always_comb begin
    nxt = state == IDLE ? ((cnt != 2'd0 && (!core_req || last_core)) ? DL_WR : core_req ? CORE : IDLE)
                        : mem_ack ? IDLE : state;
  end

  always_comb begin
    push_a = 1'b0;
    push_b = 1'b0;
    ea     = hold_e;
    eb     = odd_e;
    hv_n   = hold_v;
    hwa_n  = hold_wa;
    hb_n   = hold_b;
    if (acc && !ioctl_addr[0]) begin
      push_a = hold_v;
      hv_n   = 1'b1;
      hwa_n  = wa;
      hb_n   = ioctl_dout;
    end else if (acc) begin
      hv_n   = 1'b0;
      push_a = 1'b1;
      push_b = hold_v && hold_wa != wa;
      ea     = (hold_v && hold_wa == wa) ? {wa, ioctl_dout, hold_b, 2'b11} : hold_v ? hold_e : odd_e;
    end else if (flush_go) begin
      push_a = hold_v;
      hv_n   = 1'b0;
    end
  end

  // pop shifts the head out first, so pushes always land at the new tail
  always_comb begin
    nq   = q;
    ncnt = cnt;
    if (pop) begin
      nq[0] = q[1];
      ncnt  = cnt - 2'd1;
    end
    if (push_a) begin
      nq[ncnt[0]] = ea;
      ncnt        = ncnt + 2'd1;
    end
    if (push_b) begin
      nq[ncnt[0]] = eb;
      ncnt        = ncnt + 2'd1;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else          state <= nxt;

  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      q          <= '{default: '0};
      cnt        <= 2'd0;
      hold_v     <= 1'b0;
      hold_wa    <= '0;
      hold_b     <= '0;
      div_cnt    <= '0;
      clkref_n   <= 1'b1;
      dl_q       <= 1'b0;
      flush_pend <= 1'b0;
      done_pend  <= 1'b0;
      dl_done    <= 1'b0;
      last_core  <= 1'b0;
      core_drop  <= 1'b0;
      core_ack   <= 1'b0;
      core_q     <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_din    <= '0;
      mem_ds     <= '0;
    end else begin
      q          <= nq;
      cnt        <= ncnt;
      hold_v     <= hv_n;
      hold_wa    <= hwa_n;
      hold_b     <= hb_n;
      div_cnt    <= div_n;
      clkref_n   <= !(div_n == 8'd0 && ncnt == 2'd0 && ioctl_download);
      dl_q       <= ioctl_download;
      flush_pend <= (dl_q && !ioctl_download) || (flush_pend && !flush_go);
      done_pend  <= (dl_q && !ioctl_download) || (done_pend && !done_go && !(ioctl_download && !dl_q));
      dl_done    <= done_go;
      last_core  <= (state != IDLE && mem_ack) ? state == CORE : last_core;
      core_drop  <= state == CORE && (core_drop || !core_req);
      core_ack   <= state == CORE && mem_ack && core_req && !core_drop;
      core_q     <= (state == CORE && mem_ack) ? mem_q : core_q;
      mem_req    <= nxt != IDLE;
      if (state == IDLE && nxt == DL_WR)
        {mem_we, mem_addr, mem_din, mem_ds} <= {1'b1, q[0]};
      else if (state == IDLE && nxt == CORE)
        {mem_we, mem_addr, mem_din, mem_ds} <= {core_we, core_addr, core_din, core_ds};
    end

`ifdef IOCTL_ARB_STATS_EN
  logic dl_rise;
  assign dl_rise = ioctl_download && !dl_q;

  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      dl_words <= '0;
      overrun  <= 1'b0;
    end else begin
      dl_words <= dl_rise ? 24'd0 : dl_words + 24'(pop);
      overrun  <= !dl_rise && (overrun || (ioctl_wr && cnt != 2'd0));
    end
`endif
endmodule

// File: tb/tb_ioctl_mem_arbiter.sv
// tb_ioctl_mem_arbiter: directed scenarios with a 2-cycle-latency memory responder logging every completed access.
module tb_ioctl_mem_arbiter;
  logic        clk_sys = 0, reset_n = 0, ioctl_download = 0, ioctl_wr = 0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        clkref_n, dl_done;
  logic        core_req = 0, core_we = 0;
  logic [23:0] core_addr = '0;
  logic [15:0] core_din = '0;
  logic [1:0]  core_ds = '0;
  logic        core_ack;
  logic [15:0] core_q;
  logic        mem_req, mem_we, mem_ack;
  logic [23:0] mem_addr;
  logic [15:0] mem_din, mem_q;
  logic [1:0]  mem_ds;
`ifdef IOCTL_ARB_STATS_EN
  logic [23:0] dl_words;
  logic        overrun;
`endif

  int total = 0, bad = 0, n_log = 0, strobe_bad = 0, wcnt = 0;
  bit to_err = 0;
  logic        log_we [64];
  logic [23:0] log_a  [64];
  logic [15:0] log_d  [64];
  logic [1:0]  log_ds [64];

  ioctl_mem_arbiter dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .clkref_n(clkref_n), .dl_done(dl_done),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_din(core_din),
    .core_ds(core_ds), .core_ack(core_ack), .core_q(core_q), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_ds(mem_ds), .mem_ack(mem_ack), .mem_q(mem_q)
`ifdef IOCTL_ARB_STATS_EN
    , .dl_words(dl_words), .overrun(overrun)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) begin
    if (!reset_n) begin
      mem_ack <= 1'b0;
      mem_q   <= '0;
      wcnt    <= 0;
    end else begin
      mem_ack <= 1'b0;
      if (mem_req && !mem_ack) begin
        if (wcnt == 1) begin
          mem_ack <= 1'b1;
          mem_q   <= mem_we ? 16'h0000 : ~mem_addr[15:0];
          wcnt    <= 0;
          if (n_log < 64) begin
            log_we[n_log] <= mem_we;
            log_a[n_log]  <= mem_addr;
            log_d[n_log]  <= mem_din;
            log_ds[n_log] <= mem_ds;
          end
          n_log <= n_log + 1;
        end else wcnt <= wcnt + 1;
      end
    end
  end

  always @(negedge clk_sys)
    if (reset_n && !clkref_n && mem_req && mem_we) strobe_bad <= strobe_bad + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
    int k = 0;
    while (clkref_n && k < 100) begin
      @(negedge clk_sys);
      k++;
    end
    if (clkref_n) to_err = 1;
    @(negedge clk_sys);
    ioctl_wr = 1; ioctl_addr = a; ioctl_dout = d;
    @(negedge clk_sys);
    ioctl_wr = 0;
  endtask

  task automatic check_timeout(input string name);
    total++;
    if (to_err) begin
      bad++;
      $display("FAIL %s: clkref_n strobe timeout got none want strobe", name);
    end
    to_err = 0;
  endtask

  task automatic test_reset;
    reset_n = 0;
    repeat (3) @(negedge clk_sys);
    total++;
    if (clkref_n !== 1'b1 || dl_done !== 1'b0 || core_ack !== 1'b0 || core_q !== 16'h0) begin
      bad++;
      $display("FAIL reset_a: got clkref_n=%b dl_done=%b core_ack=%b core_q=%h want 1 0 0 0000", clkref_n, dl_done, core_ack, core_q);
    end
    total++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 24'h0 || mem_din !== 16'h0 || mem_ds !== 2'b00) begin
      bad++;
      $display("FAIL reset_b: got req=%b we=%b a=%h d=%h ds=%b want all zero", mem_req, mem_we, mem_addr, mem_din, mem_ds);
    end
`ifdef IOCTL_ARB_STATS_EN
    total++;
    if (dl_words !== 24'h0 || overrun !== 1'b0) begin
      bad++;
      $display("FAIL reset_stats: got dl_words=%h overrun=%b want 0 0", dl_words, overrun);
    end
`endif
    reset_n = 1;
    begin
      int lows = 0;
      repeat (12) begin
        @(negedge clk_sys);
        if (!clkref_n) lows++;
      end
      total++;
      if (lows != 0) begin
        bad++;
        $display("FAIL idle_clkref: got %0d strobes want 0 without download", lows);
      end
    end
  endtask

  task automatic test_download4;
    int base = n_log, seen = 0, at_log = -1;
    ioctl_download = 1;
    @(negedge clk_sys);
    send_byte(25'd0, 8'h11);
    send_byte(25'd1, 8'h22);
    send_byte(25'd2, 8'h33);
    send_byte(25'd3, 8'h44);
    check_timeout("dl4");
    repeat (10) begin
      @(negedge clk_sys);
      if (dl_done) seen++;
    end
    ioctl_download = 0;
    repeat (30) begin
      @(negedge clk_sys);
      if (dl_done) begin
        seen++;
        at_log = n_log - base;
      end
    end
    total++;
    if (n_log - base != 2) begin
      bad++;
      $display("FAIL dl4_count: got %0d writes want 2", n_log - base);
    end
    total++;
    if (log_we[base] !== 1'b1 || log_a[base] !== 24'h0 || log_d[base] !== 16'h2211 || log_ds[base] !== 2'b11) begin
      bad++;
      $display("FAIL dl4_w0: got we=%b a=%h d=%h ds=%b want 1 000000 2211 11", log_we[base], log_a[base], log_d[base], log_ds[base]);
    end
    total++;
    if (log_we[base+1] !== 1'b1 || log_a[base+1] !== 24'h1 || log_d[base+1] !== 16'h4433 || log_ds[base+1] !== 2'b11) begin
      bad++;
      $display("FAIL dl4_w1: got we=%b a=%h d=%h ds=%b want 1 000001 4433 11", log_we[base+1], log_a[base+1], log_d[base+1], log_ds[base+1]);
    end
    total++;
    if (seen != 1 || at_log != 2) begin
      bad++;
      $display("FAIL dl4_done: got pulses=%0d writes_at_pulse=%0d want 1 2", seen, at_log);
    end
  endtask

  task automatic test_partial_tail;
    int base = n_log, seen = 0, at_log = -1;
    ioctl_download = 1;
    @(negedge clk_sys);
    send_byte(25'h10, 8'hAA);
    send_byte(25'h11, 8'hBB);
    send_byte(25'h12, 8'hCC);
    check_timeout("tail");
    ioctl_download = 0;
    repeat (40) begin
      @(negedge clk_sys);
      if (dl_done) begin
        seen++;
        at_log = n_log - base;
      end
    end
    total++;
    if (log_a[base] !== 24'h8 || log_d[base] !== 16'hBBAA || log_ds[base] !== 2'b11) begin
      bad++;
      $display("FAIL tail_w0: got a=%h d=%h ds=%b want 000008 BBAA 11", log_a[base], log_d[base], log_ds[base]);
    end
    total++;
    if (log_a[base+1] !== 24'h9 || log_d[base+1] !== 16'h00CC || log_ds[base+1] !== 2'b01) begin
      bad++;
      $display("FAIL tail_w1: got a=%h d=%h ds=%b want 000009 00CC 01", log_a[base+1], log_d[base+1], log_ds[base+1]);
    end
    total++;
    if (seen != 1 || at_log != 2 || n_log - base != 2) begin
      bad++;
      $display("FAIL tail_done: got pulses=%0d writes_at_pulse=%0d writes=%0d want 1 2 2", seen, at_log, n_log - base);
    end
  endtask

  task automatic test_odd_single;
    int base = n_log, seen = 0;
    ioctl_download = 1;
    @(negedge clk_sys);
    send_byte(25'h7, 8'h5A);
    check_timeout("odd");
    ioctl_download = 0;
    repeat (30) begin
      @(negedge clk_sys);
      if (dl_done) seen++;
    end
    total++;
    if (n_log - base != 1 || log_a[base] !== 24'h3 || log_d[base] !== 16'h5A00 || log_ds[base] !== 2'b10) begin
      bad++;
      $display("FAIL odd_w0: got n=%0d a=%h d=%h ds=%b want 1 000003 5A00 10", n_log - base, log_a[base], log_d[base], log_ds[base]);
    end
    total++;
    if (seen != 1) begin
      bad++;
      $display("FAIL odd_done: got pulses=%0d want 1", seen);
    end
  endtask

  task automatic test_core_rr;
    int base = n_log, seen = 0, acks = 0, s0 = strobe_bad;
    ioctl_download = 1;
    @(negedge clk_sys);
    send_byte(25'h4, 8'h77);
    send_byte(25'h9, 8'h99);
    check_timeout("rr");
    core_req = 1; core_we = 0; core_addr = 24'h00ABCD;
    for (int k = 0; k < 80 && acks < 2; k++) begin
      @(negedge clk_sys);
      if (core_ack) begin
        acks++;
        total++;
        if (acks == 1 && core_q !== 16'h5432) begin
          bad++;
          $display("FAIL rr_q1: got core_q=%h want 5432", core_q);
        end
        if (acks == 2 && core_q !== 16'hEDCB) begin
          bad++;
          $display("FAIL rr_q2: got core_q=%h want EDCB", core_q);
        end
        core_addr = 24'h001234;
      end
    end
    core_req = 0;
    total++;
    if (acks != 2) begin
      bad++;
      $display("FAIL rr_acks: got %0d core acks want 2", acks);
    end
    ioctl_download = 0;
    repeat (40) begin
      @(negedge clk_sys);
      if (dl_done) seen++;
    end
    total++;
    if (n_log - base != 4 || log_we[base] !== 1'b0 || log_a[base] !== 24'h00ABCD || log_we[base+2] !== 1'b0 || log_a[base+2] !== 24'h001234) begin
      bad++;
      $display("FAIL rr_core: got n=%0d we0=%b a0=%h we2=%b a2=%h want 4 0 00ABCD 0 001234", n_log - base, log_we[base], log_a[base], log_we[base+2], log_a[base+2]);
    end
    total++;
    if (log_we[base+1] !== 1'b1 || log_a[base+1] !== 24'h2 || log_d[base+1] !== 16'h0077 || log_ds[base+1] !== 2'b01) begin
      bad++;
      $display("FAIL rr_dl0: got we=%b a=%h d=%h ds=%b want 1 000002 0077 01", log_we[base+1], log_a[base+1], log_d[base+1], log_ds[base+1]);
    end
    total++;
    if (log_we[base+3] !== 1'b1 || log_a[base+3] !== 24'h4 || log_d[base+3] !== 16'h9900 || log_ds[base+3] !== 2'b10) begin
      bad++;
      $display("FAIL rr_dl1: got we=%b a=%h d=%h ds=%b want 1 000004 9900 10", log_we[base+3], log_a[base+3], log_d[base+3], log_ds[base+3]);
    end
    total++;
    if (seen != 1 || strobe_bad != s0) begin
      bad++;
      $display("FAIL rr_done: got pulses=%0d strobes_during_write=%0d want 1 0", seen, strobe_bad - s0);
    end
  endtask

  task automatic test_core_write;
    int base = n_log, acks = 0;
    core_req = 1; core_we = 1; core_addr = 24'h123456; core_din = 16'hBEEF; core_ds = 2'b10;
    repeat (30) begin
      @(negedge clk_sys);
      if (core_ack) begin
        acks++;
        core_req = 0;
      end
    end
    core_req = 0; core_we = 0;
    total++;
    if (acks != 1 || n_log - base != 1) begin
      bad++;
      $display("FAIL cw_ack: got acks=%0d writes=%0d want 1 1", acks, n_log - base);
    end
    total++;
    if (log_we[base] !== 1'b1 || log_a[base] !== 24'h123456 || log_d[base] !== 16'hBEEF || log_ds[base] !== 2'b10) begin
      bad++;
      $display("FAIL cw_fwd: got we=%b a=%h d=%h ds=%b want 1 123456 BEEF 10", log_we[base], log_a[base], log_d[base], log_ds[base]);
    end
  endtask

  task automatic test_core_drop;
    int base = n_log, acks = 0;
    core_req = 1; core_we = 0; core_addr = 24'h000100;
    for (int k = 0; k < 30 && !mem_req; k++) @(negedge clk_sys);
    total++;
    if (!mem_req) begin
      bad++;
      $display("FAIL drop_grant: got mem_req=0 want 1");
    end
    core_req = 0;
    repeat (20) begin
      @(negedge clk_sys);
      if (core_ack) acks++;
    end
    total++;
    if (acks != 0 || n_log - base != 1 || log_a[base] !== 24'h000100) begin
      bad++;
      $display("FAIL drop_ack: got acks=%0d cycles=%0d a=%h want 0 1 000100", acks, n_log - base, log_a[base]);
    end
  endtask

  task automatic test_overrun;
    int base = n_log, seen = 0;
    ioctl_download = 1;
    @(negedge clk_sys);
    send_byte(25'h30, 8'h61);
    send_byte(25'h35, 8'h62);
    check_timeout("ovr");
    ioctl_wr = 1; ioctl_addr = 25'h40; ioctl_dout = 8'hEE;
    @(negedge clk_sys);
    ioctl_wr = 0;
`ifdef IOCTL_ARB_STATS_EN
    total++;
    if (overrun !== 1'b1) begin
      bad++;
      $display("FAIL ovr_flag: got overrun=%b want 1", overrun);
    end
`endif
    ioctl_download = 0;
    repeat (40) begin
      @(negedge clk_sys);
      if (dl_done) seen++;
    end
    total++;
    if (n_log - base != 2 || seen != 1) begin
      bad++;
      $display("FAIL ovr_count: got writes=%0d pulses=%0d want 2 1", n_log - base, seen);
    end
    total++;
    if (log_a[base] !== 24'h18 || log_d[base] !== 16'h0061 || log_ds[base] !== 2'b01 || log_a[base+1] !== 24'h1A || log_d[base+1] !== 16'h6200 || log_ds[base+1] !== 2'b10) begin
      bad++;
      $display("FAIL ovr_data: got %h/%h/%b %h/%h/%b want 000018/0061/01 00001A/6200/10", log_a[base], log_d[base], log_ds[base], log_a[base+1], log_d[base+1], log_ds[base+1]);
    end
`ifdef IOCTL_ARB_STATS_EN
    total++;
    if (dl_words !== 24'd2 || overrun !== 1'b1) begin
      bad++;
      $display("FAIL ovr_stats: got dl_words=%0d overrun=%b want 2 1", dl_words, overrun);
    end
`endif
  endtask

  task automatic test_reset_mid;
    int base = n_log, reqs = 0;
    core_req = 1; core_we = 0; core_addr = 24'h000055;
    for (int k = 0; k < 30 && !mem_req; k++) @(negedge clk_sys);
    reset_n = 0;
    #1;
    total++;
    if (mem_req !== 1'b0 || clkref_n !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid: got mem_req=%b clkref_n=%b want 0 1", mem_req, clkref_n);
    end
    core_req = 0;
    repeat (2) @(negedge clk_sys);
    reset_n = 1;
    repeat (10) begin
      @(negedge clk_sys);
      if (mem_req) reqs++;
    end
    total++;
    if (reqs != 0 || n_log != base) begin
      bad++;
      $display("FAIL rst_after: got req_cycles=%0d completions=%0d want 0 0", reqs, n_log - base);
    end
  endtask

  initial begin
    test_reset;
    test_download4;
    test_partial_tail;
    test_odd_single;
    test_core_rr;
    test_core_write;
    test_core_drop;
    test_overrun;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ioctl_mem_arbiter.md
Name: ioctl_mem_arbiter

Overview:
- Sits between the data_io download port (ioctl_*) and a single 16-bit word memory port (SDRAM controller front end), shared with one core requester.
- Packs the download byte stream into 16-bit words and paces data_io via clkref_n.
- Round-robin arbitrates memory access between queued download writes and core read/write requests.
- Signals download completion only once every byte has reached memory.

Parameters:
- CLKREF_DIV, 4, clkref_n strobe period in clk_sys cycles (legal range 2..255).
- ADDR_BASE, 24'h000000, word offset added to every download word address.

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- ioctl_download  in  1  download active (from data_io)
- ioctl_wr  in  1  byte strobe (from data_io)
- ioctl_addr  in  25  byte address
- ioctl_dout  in  8  byte data
- clkref_n  out  1  pacing strobe to data_io, active low, one cycle
- dl_done  out  1  one-cycle pulse: download ended and fully written
- core_req  in  1  core request, level, held until core_ack
- core_we  in  1  core write
- core_addr  in  24  core word address
- core_din  in  16  core write data
- core_ds  in  2  core byte enables ([0] = low byte)
- core_ack  out  1  one-cycle completion pulse
- core_q  out  16  read data, valid when core_ack=1
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  memory write
- mem_addr  out  24  memory word address
- mem_din  out  16  memory write data
- mem_ds  out  2  memory byte enables
- mem_ack  in  1  one-cycle completion pulse from memory
- mem_q  in  16  memory read data, valid with mem_ack

Behaviour:
- Reset values: clkref_n=1; all other outputs 0; queue, hold register, counter and FSM cleared. Reset mid-transfer drops pending data and deasserts mem_req.
- Byte-to-word mapping:
  - Word address = ioctl_addr[24:1] + ADDR_BASE, modulo 2^24.
  - Even byte → [7:0], ds[0]; odd byte → [15:8], ds[1].
- Byte packing, via hold register (hold_v, hold_wa, hold_b):
  - Even byte while hold empty: store in hold.
  - Even byte while hold full: push the old hold as a partial word (ds=01), then store the new byte in hold.
  - Odd byte with hold_v and hold_wa equal to its word address: push {byte, hold_b}, ds=11; clear hold.
  - Odd byte otherwise: if hold_v, push hold partial (ds=01) first. Then push {byte, 8'h00}, ds=10.
  - Pushes from a single ioctl_wr complete within that cycle and the next; write queue is a 2-entry FIFO.
- clkref_n:
  - Free-running counter 0..CLKREF_DIV-1.
  - clkref_n=0 for one cycle when counter==0, queue empty, and ioctl_download=1. Otherwise clkref_n=1.
  - This guarantees ≥2 free entries whenever data_io writes (ioctl_wr comes one cycle after the strobe).
- ioctl_wr while queue is not empty is a protocol violation. Drop the byte; do not corrupt queued entries.
- Download end: on ioctl_download 1→0 with hold_v, push hold partial (ds=01).
  - dl_done pulses one cycle once download=0, hold empty, queue empty and no download write is in flight.
  - A new download (0→1) before dl_done cancels the pending dl_done but keeps queued data.
- FSM states: IDLE, DL_WR, CORE.
  - IDLE → DL_WR if queue non-empty and (no core_req or last_grant=CORE).
  - IDLE → CORE if core_req and (queue empty or last_grant=DL).
  - Grant drives mem_req in the cycle after the IDLE decision.
  - DL_WR/CORE → IDLE on mem_ack. last_grant is updated on that transition.
  - DL_WR: mem_we=1 with the queue head; pop on mem_ack.
  - CORE: forward core_we/addr/din/ds. On mem_ack, core_ack=1 and core_q=mem_q (registered).
- Memory port outputs hold stable while mem_req=1.
- A core_req dropped before core_ack is a protocol violation. The FSM completes the memory cycle and suppresses core_ack.
- Minimum turnaround: one IDLE cycle between memory cycles.

Optional Feature:
- IOCTL_ARB_STATS_EN:
  - With it, add outputs dl_words (24-bit count of download words written, cleared on ioctl_download 0→1) and overrun (sticky; set on a dropped ioctl_wr, cleared on ioctl_download 0→1 or reset).
  - Without it, neither port exists and dropped bytes go unreported.

Test Plan:
- 4-byte download, addr 0..3, data 11,22,33,44, mem_ack after 2 cycles → two writes: wa 0 data 2211 ds 11, wa 1 data 4433 ds 11; dl_done one pulse after the last ack.
- 3-byte download at addr 0x10 (bytes AA,BB,CC), then download drop → wa 8 BBAA ds 11; wa 9 00CC ds 01; then dl_done.
- Single odd byte 5A at addr 7 → wa 3 data 5A00 ds 10.
- Even byte at addr 4, then next byte at addr 9 → wa 2 partial ds 01, then wa 4 ds 10.
- Core read pending throughout a download → grants alternate DL, CORE, DL; core_ack with core_q=mem_q; no clkref_n strobe while the queue is non-empty.
- Drive an extra ioctl_wr with the queue full → byte dropped, queue contents unchanged; with IOCTL_ARB_STATS_EN, overrun=1 and dl_words excludes the dropped byte.
